// File: rtl/fetch_pkg.sv
// Shared defaults and the queue entry type for the instruction fetch unit.
package fetch_pkg;

    localparam int IMEM_W_DEF = 14;
    localparam int W_DEF      = 32;
    localparam logic [IMEM_W_DEF-1:0] RESET_PC_DEF = 14'h0000;

    // Depth of the fetch/decode decoupling queue.
    localparam logic [1:0] FIFO_DEPTH = 2'd2;

    typedef struct packed {
        logic [IMEM_W_DEF-1:0] pc;
        logic [W_DEF-1:0]      inst;
    } fetch_entry_t;

    // True when a queue holding 'cnt' entries has room for one more.
    function automatic logic has_room(input logic [1:0] cnt);
        return (cnt < FIFO_DEPTH);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry queue of fetched {pc, instruction} pairs with push, pop and flush.
// Push and pop in the same cycle keep the count and the order intact; flush
// wins over both and empties the queue. Storage itself is never reset.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter type entry_t = fetch_entry_t
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic       pop,
    input  logic       flush,
    input  entry_t     wr_data,
    output entry_t     rd_data,
    output logic [1:0] count
);

    entry_t     mem_r [2];
    logic       rd_ptr_r;
    logic       wr_ptr_r;
    logic [1:0] count_r;

    // Pointer and occupancy bookkeeping; flush returns everything to empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_r <= 1'b0;
            wr_ptr_r <= 1'b0;
            count_r  <= 2'd0;
        end else if (flush) begin
            rd_ptr_r <= 1'b0;
            wr_ptr_r <= 1'b0;
            count_r  <= 2'd0;
        end else begin
            if (push) begin
                wr_ptr_r <= ~wr_ptr_r;
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop) begin
                rd_ptr_r <= ~rd_ptr_r;
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({push, pop})
                2'b10:   count_r <= count_r + 2'd1;
                2'b01:   count_r <= count_r - 2'd1;
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage; when full with a simultaneous pop the write slot is the
    // one being vacated, so the overwrite is safe.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    assign rd_data = mem_r[rd_ptr_r];
    assign count   = count_r;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: a PC register addresses instruction memory and
// the returned word is queued with its address for the decode stage.
// A redirect flushes the queue and reloads the PC in the same edge.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int IMEM_W = IMEM_W_DEF,
    parameter int W      = W_DEF,
    parameter logic [IMEM_W-1:0] RESET_PC = IMEM_W'(RESET_PC_DEF)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    output logic [IMEM_W-1:0] imem_addr_o,
    input  logic [W-1:0]      imem_data_i,
    input  logic              redirect_i,
    input  logic [IMEM_W-1:0] redirect_pc_i,
    output logic [W-1:0]      inst_o,
    output logic [IMEM_W-1:0] pc_o,
    output logic              valid_o,
    input  logic              ready_i
);

    typedef struct packed {
        logic [IMEM_W-1:0] pc;
        logic [W-1:0]      inst;
    } entry_t;

    logic [IMEM_W-1:0] pc_r;
    logic [1:0]        count_s;
    logic              pop_s;
    logic              fetch_s;
    entry_t            wr_entry_s;
    entry_t            head_s;

    // Delivery and fetch decisions; a redirect suppresses both this cycle.
    always_comb begin
        valid_o = 1'b0;
        pop_s   = 1'b0;
        fetch_s = 1'b0;
        if (redirect_i) begin
            valid_o = 1'b0;
            pop_s   = 1'b0;
            fetch_s = 1'b0;
        end else begin
            valid_o = (count_s != 2'd0);
            pop_s   = valid_o && ready_i;
            fetch_s = has_room(count_s) || pop_s;
        end
    end

    // Program counter: redirect target (word aligned) beats sequential advance.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pc_r <= RESET_PC;
        end else if (redirect_i) begin
            pc_r <= {redirect_pc_i[IMEM_W-1:2], 2'b00};
        end else if (fetch_s) begin
            pc_r <= pc_r + IMEM_W'(4);
        end else begin
            pc_r <= pc_r;
        end
    end

    assign wr_entry_s = '{pc: pc_r, inst: imem_data_i};

    fetch_fifo #(
        .entry_t (entry_t)
    ) u_fifo (
        .clk     (clk_i),
        .rst_n   (rst_ni),
        .push    (fetch_s),
        .pop     (pop_s),
        .flush   (redirect_i),
        .wr_data (wr_entry_s),
        .rd_data (head_s),
        .count   (count_s)
    );

    assign imem_addr_o = pc_r;
    assign inst_o      = head_s.inst;
    assign pc_o        = head_s.pc;

endmodule
